// File: rtl/reg_file_2r1w_if.sv
// reg_file_2r1w_if: read/write bus of the 2-read / 1-write register file.
//   master : ID/WB side. Drives the read addresses and the write port, and
//            receives the read data.
//   slave  : the register file.
// Signals:
//   ReadReg1/ReadReg2   read port addresses (rs / rt)
//   ReadData1/ReadData2 read port data
//   WriteReg/WriteData  write port address / data (from WB)
//   RegWrite            write enable from WB control
interface reg_file_2r1w_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] ReadReg1;
    logic [ADDR_WIDTH-1:0] ReadReg2;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;
    logic [ADDR_WIDTH-1:0] WriteReg;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  RegWrite;

    modport master (
        output ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: architectural integer register file, 2**ADDR_WIDTH words of
// DATA_WIDTH bits. Word 0 is hard-wired to zero. Two combinational read ports
// with write-to-read bypass, one synchronous write port.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; clears every word while low
//   rf     reg_file_2r1w_if.slave bus (read addresses/data, write port)
module reg_file_2r1w #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic            clk,
    input  logic            reset,
    reg_file_2r1w_if.slave  rf
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    // Storage exists only for words 1..NUM_REGS-1; word 0 is a constant.
    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [NUM_REGS-1:0]   wr_en;

    logic [DATA_WIDTH-1:0] rd1_stored;
    logic [DATA_WIDTH-1:0] rd2_stored;
    logic                  byp1;
    logic                  byp2;

    // One-hot write decode gated by RegWrite. WriteReg is only used as an
    // index when RegWrite is set, so X on it is harmless otherwise.
    always_comb begin
        wr_en = '0;
        if (rf.RegWrite) begin
            wr_en[rf.WriteReg] = 1'b1;
        end
        wr_en[0] = 1'b0;
    end

    for (genvar k = 1; k < NUM_REGS; k++) begin : g_word
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                regs_q[k] <= '0;
            end else if (wr_en[k]) begin
                regs_q[k] <= rf.WriteData;
            end
        end
    end

    // Read muxes; address 0 selects the constant-zero word.
    always_comb begin
        rd1_stored = '0;
        rd2_stored = '0;
        if (rf.ReadReg1 != '0) begin
            rd1_stored = regs_q[rf.ReadReg1];
        end
        if (rf.ReadReg2 != '0) begin
            rd2_stored = regs_q[rf.ReadReg2];
        end
    end

    // Bypass only while out of reset, so every read is zero during reset.
    // RegWrite is tested first so X addresses cannot leak into the select.
    always_comb begin
        byp1 = 1'b0;
        byp2 = 1'b0;
        if (reset && rf.RegWrite && (rf.WriteReg != '0)) begin
            byp1 = (rf.WriteReg == rf.ReadReg1);
            byp2 = (rf.WriteReg == rf.ReadReg2);
        end
    end

    assign rf.ReadData1 = byp1 ? rf.WriteData : rd1_stored;
    assign rf.ReadData2 = byp2 ? rf.WriteData : rd2_stored;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: self-checking bench for reg_file_2r1w. Directed vector
// table, hand-written reset sequences, and a randomized run checked against
// an array model of the register contents.
module tb_reg_file_2r1w;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2 ** AW;

    logic clk;
    logic reset;

    reg_file_2r1w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    reg_file_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] model [NR];

    typedef struct {
        logic [AW-1:0] rr1;
        logic [AW-1:0] rr2;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Apply inputs at the falling edge; the caller waits #1 before checking.
    task automatic drive(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        @(negedge clk);
        bus.ReadReg1  = r1;
        bus.ReadReg2  = r2;
        bus.RegWrite  = we;
        bus.WriteReg  = wa;
        bus.WriteData = wd;
    endtask

    // Advance through the rising edge and commit the write to the model.
    task automatic edge_update();
        @(posedge clk);
        if (reset === 1'b1 && bus.RegWrite === 1'b1 && bus.WriteReg != '0)
            model[bus.WriteReg] = bus.WriteData;
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        for (int i = 0; i < int'(NR); i++) model[i] = '0;
    endtask

    // Expected read value derived from the current model and the inputs
    // presented to the write port this cycle.
    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (reset !== 1'b1) return '0;
        if (a == '0) return '0;
        if (bus.RegWrite === 1'b1 && bus.WriteReg == a) return bus.WriteData;
        return model[a];
    endfunction

    initial begin
        logic [AW-1:0] r1, r2, wa;
        logic          we;
        logic [DW-1:0] wd;

        // Reset state: even an enabled write is invisible while reset is low.
        assert_reset();
        bus.ReadReg1  = 5'd5;
        bus.ReadReg2  = 5'd5;
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd5;
        bus.WriteData = 32'h0000_00FF;
        #3;
        check("reset_rd1", bus.ReadData1, 32'h0);
        check("reset_rd2", bus.ReadData2, 32'h0);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        reset = 1'b1;
        #1;

        // Asynchronous reset drops stored data without a clock edge.
        drive(5'd5, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        edge_update();
        drive(5'd5, 5'd0, 1'b0, 5'd0, 32'h0);
        #1;
        check("r5_before_reset", bus.ReadData1, 32'hDEAD_BEEF);
        #2;
        assert_reset();
        #1;
        check("r5_async_reset", bus.ReadData1, 32'h0);
        edge_update();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < int'(NR); i++) begin
            drive(AW'(i), AW'(int'(NR) - 1 - i), 1'b0, 5'd0, 32'h0);
            #1;
            check($sformatf("post_reset_rd1[%0d]", i), bus.ReadData1, 32'h0);
            check($sformatf("post_reset_rd2[%0d]", 31 - i), bus.ReadData2, 32'h0);
            edge_update();
        end

        // Directed vector table, starting from all-zero contents.
        vecs.push_back('{5'd1,  5'd31, 1'b1, 5'd1,  32'h0000_0011, 32'h0000_0011, 32'h0000_0000});
        vecs.push_back('{5'd1,  5'd31, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0000_0011, 32'hFFFF_FFFF});
        vecs.push_back('{5'd1,  5'd31, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_0011, 32'hFFFF_FFFF});
        vecs.push_back('{5'd31, 5'd1,  1'b0, 5'd0,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0011});
        vecs.push_back('{5'd0,  5'd0,  1'b1, 5'd0,  32'h1234_5678, 32'h0000_0000, 32'h0000_0000});
        vecs.push_back('{5'd0,  5'd0,  1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
        vecs.push_back('{5'd7,  5'd1,  1'b1, 5'd7,  32'hAAAA_0000, 32'hAAAA_0000, 32'h0000_0011});
        vecs.push_back('{5'd7,  5'd7,  1'b1, 5'd7,  32'h0000_BBBB, 32'h0000_BBBB, 32'h0000_BBBB});
        vecs.push_back('{5'd7,  5'd7,  1'b0, 5'd0,  32'h0000_0000, 32'h0000_BBBB, 32'h0000_BBBB});
        vecs.push_back('{5'd3,  5'd4,  1'b0, 5'd3,  32'h0000_0055, 32'h0000_0000, 32'h0000_0000});
        vecs.push_back('{5'd4,  5'd3,  1'b1, 5'd3,  32'h0000_0055, 32'h0000_0000, 32'h0000_0055});
        vecs.push_back('{5'd3,  5'd4,  1'b0, 5'd0,  32'h0000_0000, 32'h0000_0055, 32'h0000_0000});
        vecs.push_back('{5'd12, 5'd12, 1'b1, 5'd12, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001});
        vecs.push_back('{5'd12, 5'd5,  1'b1, 5'd12, 32'h0000_0002, 32'h0000_0002, 32'h0000_0000});
        vecs.push_back('{5'd12, 5'd12, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_0002, 32'h0000_0002});
        vecs.push_back('{5'd12, 5'd7,  1'b0, 'x,    'x,            32'h0000_0002, 32'h0000_BBBB});
        vecs.push_back('{5'd31, 5'd1,  1'b0, 'x,    'x,            32'hFFFF_FFFF, 32'h0000_0011});

        foreach (vecs[i]) begin
            drive(vecs[i].rr1, vecs[i].rr2, vecs[i].we, vecs[i].wa, vecs[i].wd);
            #1;
            check($sformatf("vec%0d_rd1", i), bus.ReadData1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), bus.ReadData2, vecs[i].e2);
            edge_update();
        end

        // Reset held low across a write edge discards that write.
        drive(5'd9, 5'd9, 1'b1, 5'd9, 32'h0000_0099);
        #1;
        check("r9_bypass", bus.ReadData1, 32'h0000_0099);
        #1;
        assert_reset();
        #1;
        check("r9_bypass_in_reset", bus.ReadData2, 32'h0);
        edge_update();
        drive(5'd9, 5'd3, 1'b0, 5'd0, 32'h0);
        reset = 1'b1;
        #1;
        check("r9_after_reset", bus.ReadData1, 32'h0);
        check("r3_after_reset", bus.ReadData2, 32'h0);
        edge_update();

        // Randomized traffic against the array model, with rare async resets.
        for (int n = 0; n < 600; n++) begin
            we = ($urandom_range(3) != 0);
            wa = AW'($urandom_range(NR - 1));
            wd = $urandom;
            r1 = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(NR - 1));
            r2 = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(NR - 1));
            drive(r1, r2, we, wa, wd);
            if (reset !== 1'b1) reset = 1'b1;
            #1;
            check($sformatf("rand%0d_rd1", n), bus.ReadData1, exp_read(r1));
            check($sformatf("rand%0d_rd2", n), bus.ReadData2, exp_read(r2));
            if ($urandom_range(39) == 0) begin
                #1;
                assert_reset();
                #1;
                check($sformatf("rand%0d_rst_rd1", n), bus.ReadData1, 32'h0);
                check($sformatf("rand%0d_rst_rd2", n), bus.ReadData2, 32'h0);
            end
            edge_update();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
